// File: rtl/eth_csr_pkg.sv
// Shared definitions for the Ethernet CSR mailbox
// control word (MMIO side and Avalon master side).
package eth_csr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_REQ,
    ST_RD_WAIT
  } t_eth_csr_state;

  localparam int ETH_CMD_WR_BIT = 16;
  localparam int ETH_CMD_RD_BIT = 17;
  localparam int ETH_CSR_ADDR_W = 16;

endpackage

// File: rtl/eth_csr_avmm_master.sv
// Executes mailbox control-word commands as single
// Avalon-MM transactions with a bounded timeout.
module eth_csr_avmm_master
  import eth_csr_pkg::*;
#(
  parameter int          ADDR_W           = ETH_CSR_ADDR_W,
  parameter int          TIMEOUT_CYCLES   = 1023,
  parameter logic [31:0] TIMEOUT_RD_VALUE = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              pck_cp2af_softReset_T1,
  input  logic [31:0]       eth_ctrl_addr,
  input  logic [31:0]       eth_wr_data,
  output logic [31:0]       eth_rd_data,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_drop,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT_CYCLES);

  t_eth_csr_state state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              err_to_q, err_to_d;
  logic              err_drop_q, err_drop_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;

  logic wr_stb, rd_stb;
  logic cmd_wr, cmd_rd, cmd_both;
  logic cnt_hit;

  // Upper control-word bits carry no meaning here.
  logic unused_ctrl;
  assign unused_ctrl = ^eth_ctrl_addr[31:18];

  assign wr_stb   = eth_ctrl_addr[ETH_CMD_WR_BIT];
  assign rd_stb   = eth_ctrl_addr[ETH_CMD_RD_BIT];
  assign cmd_both = wr_stb & rd_stb;
  assign cmd_wr   = wr_stb & ~rd_stb;
  assign cmd_rd   = rd_stb & ~wr_stb;

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign cnt_hit = (cnt_inc == CNT_MAX);

  // Next-state, timeout and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    err_to_d   = err_to_q;
    err_drop_d = err_drop_q;

    if (state_q != ST_IDLE && (wr_stb || rd_stb))
      err_drop_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        unique case (1'b1)
          cmd_both: err_drop_d = 1'b1;
          cmd_wr: begin
            addr_d     = eth_ctrl_addr[ADDR_W-1:0];
            wdata_d    = eth_wr_data;
            err_to_d   = 1'b0;
            err_drop_d = 1'b0;
            cnt_d      = '0;
            state_d    = ST_WR;
          end
          cmd_rd: begin
            addr_d     = eth_ctrl_addr[ADDR_W-1:0];
            err_to_d   = 1'b0;
            err_drop_d = 1'b0;
            cnt_d      = '0;
            state_d    = ST_RD_REQ;
          end
          default: ;
        endcase
      end
      ST_WR: begin
        if (!avm_waitrequest) begin
          state_d = ST_IDLE;
        end else if (cnt_hit) begin
          err_to_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RD_REQ: begin
        if (!avm_waitrequest) begin
          if (avm_readdatavalid) begin
            rd_data_d = avm_readdata;
            state_d   = ST_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = ST_RD_WAIT;
          end
        end else if (cnt_hit) begin
          err_to_d  = 1'b1;
          rd_data_d = TIMEOUT_RD_VALUE;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RD_WAIT: begin
        if (avm_readdatavalid) begin
          rd_data_d = avm_readdata;
          state_d   = ST_IDLE;
        end else if (cnt_hit) begin
          err_to_d  = 1'b1;
          rd_data_d = TIMEOUT_RD_VALUE;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rd_d   = (state_d == ST_RD_REQ);
    wr_d   = (state_d == ST_WR);
    busy_d = (state_d != ST_IDLE);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge pck_cp2af_softReset_T1) begin
    if (pck_cp2af_softReset_T1) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      err_to_q   <= 1'b0;
      err_drop_q <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      err_to_q   <= err_to_d;
      err_drop_q <= err_drop_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
    end
  end

  assign eth_rd_data   = rd_data_q;
  assign busy          = busy_q;
  assign err_timeout   = err_to_q;
  assign err_drop      = err_drop_q;
  assign avm_address   = addr_q;
  assign avm_read      = rd_q;
  assign avm_write     = wr_q;
  assign avm_writedata = wdata_q;

endmodule
